frame_l2_in: RTL and testbench
==============================

FRAME_L2_IN -- requirements
Module: frame_l2_in

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1522, maximum legal frame length in bytes after SFD, FCS included.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port LINK_UP  input  1  PHY link status; frames are ignored while low.
REQ-006 SHALL have port RxVal  input  1  receive data valid, one nibble per Clk.
REQ-007 SHALL have port RxData  input  4  receive nibble, low nibble of each byte first.
REQ-008 SHALL have port ValOut  output  1  DataOut valid strobe.
REQ-009 SHALL have port SoFOut  output  1  first byte of frame, qualified by ValOut.
REQ-010 SHALL have port EoFOut  output  1  last byte of frame, qualified by ValOut.
REQ-011 SHALL have port ErrOut  output  1  frame bad; valid only with EoFOut.
REQ-012 SHALL have port DataOut  output  8  received byte.
REQ-013 SHALL have port GoodCnt  output  16  count of good frames, saturating.
REQ-014 SHALL have port ErrCnt  output  16  count of bad or dropped frames, saturating.

Function
REQ-015 SHALL run FSM states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: SHALL go to PREAMBLE on an RxVal rising edge with LINK_UP high; with LINK_UP low SHALL go to DROP.
REQ-017 PREAMBLE: nibble 0x5 SHALL stay; nibble 0xD SHALL enter DATA with nibble phase = low; any other nibble SHALL enter DROP; RxVal low SHALL return to IDLE with no output and no count change.
REQ-018 DATA: SHALL assemble byte {high, low} on each high nibble and feed it to CRC and the holdback chain of depth D.
REQ-019 SHALL emit the oldest chain byte, 1 clock after the high nibble that overfills the chain, with ValOut=1 and SoFOut=1 for the first emitted byte.
REQ-020 On RxVal low in DATA, SHALL emit the oldest chain byte 1 clock later with EoFOut=1, then enter IDLE.
REQ-021 A frame of exactly D bytes SHALL emit one byte with SoFOut=EoFOut=1.
REQ-022 A frame of fewer than D bytes SHALL emit nothing and SHALL increment ErrCnt.
REQ-023 CRC-32 SHALL be reflected polynomial 0xEDB88320, init 0xFFFFFFFF, over all bytes after SFD including FCS; frame CRC good iff register = 0xDEBB20E3 at end.
REQ-024 ErrOut SHALL be 1 on EoF if CRC bad, odd nibble count, byte count < MIN_LEN, or byte count > MAX_LEN; the byte counter SHALL saturate at MAX_LEN+1.
REQ-025 On each EoF, GoodCnt SHALL increment if ErrOut=0, else ErrCnt SHALL increment; both counters SHALL saturate at 0xFFFF.
REQ-026 DROP: SHALL emit nothing and SHALL return to IDLE when RxVal is low; entry from PREAMBLE on a bad nibble SHALL increment ErrCnt.
REQ-027 SHALL keep ValOut, SoFOut and EoFOut to one-clock pulses; ValOut SHALL never be high on two consecutive clocks.

Reset
REQ-028 Rst SHALL set the state to IDLE, all outputs and counters to 0, the CRC register to 0xFFFFFFFF, and the chain to empty.
REQ-029 The registered previous RxVal SHALL reset to 1, so that a frame in progress at reset release is not captured; capture SHALL restart only after RxVal is low for at least 1 clock.

Configuration
REQ-030 With FRAME_L2_IN_CRC_STRIP_EN defined, D SHALL be 5, so the 4 FCS bytes are withheld and EoFOut marks the last payload byte.
REQ-031 Without FRAME_L2_IN_CRC_STRIP_EN, D SHALL be 1, so the FCS bytes pass through and EoFOut marks the last FCS byte; CRC checking SHALL be identical in both builds.

Structure
REQ-032 Package frame_l2_pkg SHALL hold the FSM state typedef, CRC_INIT, CRC_POLY, CRC_RESIDUE, PREAMBLE_NIB=0x5 and SFD_NIB=0xD.
REQ-033 Sub-module crc32_byte_next SHALL compute the next CRC state combinationally from the current state and one byte.

Verification
REQ-034 7x0x55, 0xD5, bytes 0x00..0x3B, correct FCS (64 B) -> 60 bytes (strip) or 64 bytes (no strip) out, SoF on 0x00, ErrOut=0, GoodCnt=1.
REQ-035 Same frame with FCS byte 0 XOR 0x01 -> same byte count out, EoF with ErrOut=1, ErrCnt=1.
REQ-036 Preamble nibble 0x7 inserted -> no output, ErrCnt=1, next valid frame received good.
REQ-037 Valid 40-byte frame -> ErrOut=1 (runt); frame with 1 extra nibble -> ErrOut=1 (alignment).
REQ-038 Rst asserted mid-frame with RxVal held high -> no output until RxVal low, then next frame good, GoodCnt=1.
REQ-039 LINK_UP=0 during a full good frame -> no output, both counters unchanged.

Source files
------------

// File: rtl/frame_l2_pkg.sv
// Shared state type and protocol constants for the frame_l2_in nibble receiver.
package frame_l2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_byte_next.sv
// Combinational next-state of the reflected CRC-32 register for one input byte.
module crc32_byte_next
  import frame_l2_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  // Byte is folded into the low end, then eight LSB-first division steps.
  always_comb begin
    w_crc = i_crc ^ {24'd0, i_byte};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
    end
  end

  assign o_crc = w_crc;

endmodule

// File: rtl/frame_l2_in.sv
// Layer-2 nibble receiver: preamble/SFD hunt, byte assembly, CRC-32 and length checks.
// FRAME_L2_IN_CRC_STRIP_EN: withhold the 4 FCS bytes (holdback depth 5 instead of 1).
module frame_l2_in
  import frame_l2_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        LINK_UP,
  input  logic        RxVal,
  input  logic [3:0]  RxData,
  output logic        ValOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic        ErrOut,
  output logic [7:0]  DataOut,
  output logic [15:0] GoodCnt,
  output logic [15:0] ErrCnt
);

`ifdef FRAME_L2_IN_CRC_STRIP_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif
  localparam int CW = $clog2(MAX_LEN + 2);
  localparam int DW = $clog2(D + 1);
  localparam logic [CW-1:0] LEN_MIN    = CW'(MIN_LEN);
  localparam logic [CW-1:0] LEN_MAX    = CW'(MAX_LEN);
  localparam logic [CW-1:0] LEN_SAT    = CW'(MAX_LEN + 1);
  localparam logic [DW-1:0] CHAIN_FULL = DW'(D);

  state_t        r_state, w_next;
  logic          r_rxValPrev, r_phase, r_sent, r_eofPend;
  logic [3:0]    r_lowNib;
  logic [31:0]   r_crc, w_crcNext;
  logic [7:0]    r_chain [D];
  logic [DW-1:0] r_chainCnt;
  logic [CW-1:0] r_byteCnt;
  logic          r_val, r_sof, r_eof, r_err;
  logic [7:0]    r_data;
  logic [15:0]   r_goodCnt, r_errCnt;
  logic          w_rise, w_sfd, w_preErr, w_lowNib, w_push, w_frameEnd, w_bad;

  crc32_byte_next u_crc (
    .i_crc  (r_crc),
    .i_byte ({RxData, r_lowNib}),
    .o_crc  (w_crcNext)
  );

  assign w_rise = RxVal & ~r_rxValPrev;
  assign w_bad  = (r_crc != CRC_RESIDUE) | r_phase |
                  (r_byteCnt < LEN_MIN) | (r_byteCnt > LEN_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_rise) w_next = LINK_UP ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!RxVal)                       w_next = IDLE;
        else if (RxData == SFD_NIB)       w_next = DATA;
        else if (RxData != PREAMBLE_NIB)  w_next = DROP;
      end
      DATA:     if (!RxVal) w_next = IDLE;
      DROP:     if (!RxVal) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sfd      = 1'b0;
    w_preErr   = 1'b0;
    w_lowNib   = 1'b0;
    w_push     = 1'b0;
    w_frameEnd = 1'b0;
    case (r_state)
      PREAMBLE: if (RxVal) begin
        w_sfd    = (RxData == SFD_NIB);
        w_preErr = (RxData != SFD_NIB) && (RxData != PREAMBLE_NIB);
      end
      DATA: begin
        w_lowNib   = RxVal & ~r_phase;
        w_push     = RxVal & r_phase;
        w_frameEnd = ~RxVal;
      end
      default: ;
    endcase
  end

  // Frame state is cleared at SFD rather than at frame end, so the deferred
  // EoF cycle can still read the last frame's chain, CRC and length.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rxValPrev <= 1'b1;
      r_phase     <= 1'b0;
      r_sent      <= 1'b0;
      r_eofPend   <= 1'b0;
      r_lowNib    <= '0;
      r_crc       <= CRC_INIT;
      r_chainCnt  <= '0;
      r_byteCnt   <= '0;
      for (int i = 0; i < D; i++) r_chain[i] <= '0;
      r_val       <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_goodCnt   <= '0;
      r_errCnt    <= '0;
    end else begin
      r_rxValPrev <= RxVal;
      r_eofPend   <= w_frameEnd;
      r_val       <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_err       <= 1'b0;
      if (w_sfd) begin
        r_crc      <= CRC_INIT;
        r_chainCnt <= '0;
        r_byteCnt  <= '0;
        r_phase    <= 1'b0;
        r_sent     <= 1'b0;
      end
      if (w_lowNib) begin
        r_lowNib <= RxData;
        r_phase  <= 1'b1;
      end
      if (w_push) begin
        r_phase    <= 1'b0;
        r_crc      <= w_crcNext;
        r_chain[0] <= {RxData, r_lowNib};
        for (int i = 1; i < D; i++) r_chain[i] <= r_chain[i-1];
        if (r_byteCnt != LEN_SAT) r_byteCnt <= r_byteCnt + CW'(1);
        if (r_chainCnt == CHAIN_FULL) begin
          r_val  <= 1'b1;
          r_sof  <= ~r_sent;
          r_data <= r_chain[D-1];
          r_sent <= 1'b1;
        end else begin
          r_chainCnt <= r_chainCnt + DW'(1);
        end
      end
      if (r_eofPend) begin
        if (r_chainCnt == CHAIN_FULL) begin
          r_val  <= 1'b1;
          r_eof  <= 1'b1;
          r_sof  <= ~r_sent;
          r_err  <= w_bad;
          r_data <= r_chain[D-1];
          if (w_bad) r_errCnt  <= satInc16(r_errCnt);
          else       r_goodCnt <= satInc16(r_goodCnt);
        end else begin
          r_errCnt <= satInc16(r_errCnt);
        end
      end
      if (w_preErr) r_errCnt <= satInc16(r_errCnt);
    end
  end

  assign ValOut  = r_val;
  assign SoFOut  = r_sof;
  assign EoFOut  = r_eof;
  assign ErrOut  = r_err;
  assign DataOut = r_data;
  assign GoodCnt = r_goodCnt;
  assign ErrCnt  = r_errCnt;

endmodule

// File: tb/tb_frame_l2_in.sv
// Directed scoreboard bench for frame_l2_in; follows FRAME_L2_IN_CRC_STRIP_EN like the DUT.
module tb_frame_l2_in;

`ifdef FRAME_L2_IN_CRC_STRIP_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;

  logic        Clk, Rst, LINK_UP, RxVal;
  logic [3:0]  RxData;
  logic        ValOut, SoFOut, EoFOut, ErrOut;
  logic [7:0]  DataOut;
  logic [15:0] GoodCnt, ErrCnt;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } exp_t;

  exp_t       expQ [$];
  exp_t       monExp;
  logic [7:0] frm [$];
  int         checks = 0;
  int         errors = 0;
  int         expGood = 0;
  int         expErr = 0;
  logic       prevVal = 1'b0;

  frame_l2_in #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .LINK_UP (LINK_UP),
    .RxVal   (RxVal),
    .RxData  (RxData),
    .ValOut  (ValOut),
    .SoFOut  (SoFOut),
    .EoFOut  (EoFOut),
    .ErrOut  (ErrOut),
    .DataOut (DataOut),
    .GoodCnt (GoodCnt),
    .ErrCnt  (ErrCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crcCalc(input int upto);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < upto; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Payload bytes 0,1,2,... followed by a correct FCS, optionally corrupted.
  task automatic buildFrame(input int nPayload, input bit corrupt);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < nPayload; i++) frm.push_back(8'(i));
    fcs = ~crcCalc(nPayload);
    for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
    if (corrupt) frm[nPayload] = frm[nPayload] ^ 8'h01;
  endtask

  task automatic applyStimulus(input bit link, input bit badPre, input bit extraNib, input int rstAt);
    logic [3:0]  nibs [$];
    logic [31:0] fcsRx;
    exp_t        e;
    int          n;
    bit          crcOk, bad;
    n = frm.size();
    if (rstAt >= 0) begin
      expGood = 0;
      expErr  = 0;
    end else if (!link) begin
      expErr = expErr;
    end else if (badPre || n < D) begin
      expErr++;
    end else begin
      crcOk = 1'b0;
      if (n >= 4) begin
        fcsRx = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
        crcOk = (~crcCalc(n - 4) == fcsRx);
      end
      bad = !crcOk || extraNib || (n < MIN_LEN) || (n > MAX_LEN);
      for (int i = 0; i <= n - D; i++) begin
        e.d   = frm[i];
        e.sof = (i == 0);
        e.eof = (i == n - D);
        e.err = (i == n - D) && bad;
        expQ.push_back(e);
      end
      if (bad) expErr++;
      else     expGood++;
    end
    for (int i = 0; i < 15; i++) nibs.push_back((badPre && i == 4) ? 4'h7 : 4'h5);
    nibs.push_back(4'hD);
    for (int i = 0; i < n; i++) begin
      nibs.push_back(frm[i][3:0]);
      nibs.push_back(frm[i][7:4]);
    end
    if (extraNib) nibs.push_back(4'hA);
    LINK_UP = link;
    for (int k = 0; k < nibs.size(); k++) begin
      @(negedge Clk);
      if (k == rstAt)     Rst = 1'b1;
      if (k == rstAt + 3) Rst = 1'b0;
      RxVal  = 1'b1;
      RxData = nibs[k];
    end
    @(negedge Clk);
    RxVal = 1'b0;
    Rst   = 1'b0;
    repeat (4) @(negedge Clk);
    for (int w = 0; w < 40 && expQ.size() != 0; w++) @(negedge Clk);
    checkOutput("drain", expQ.size(), 0);
    checkOutput("good_cnt", {16'd0, GoodCnt}, expGood);
    checkOutput("err_cnt", {16'd0, ErrCnt}, expErr);
    LINK_UP = 1'b1;
  endtask

  // Output monitor: every valid byte is popped from the scoreboard and compared.
  always @(negedge Clk) begin
    if (ValOut) begin
      checkOutput("val_pulse", {31'd0, prevVal}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("spurious_val", {31'd0, ValOut}, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("out_byte", {21'd0, DataOut, SoFOut, EoFOut, EoFOut & ErrOut},
                    {21'd0, monExp.d, monExp.sof, monExp.eof, monExp.err});
      end
    end
    prevVal = ValOut;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Rst     = 1'b1;
    RxVal   = 1'b0;
    RxData  = 4'h0;
    LINK_UP = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("rst_val", {31'd0, ValOut}, 0);
    checkOutput("rst_sof", {31'd0, SoFOut}, 0);
    checkOutput("rst_eof", {31'd0, EoFOut}, 0);
    checkOutput("rst_err", {31'd0, ErrOut}, 0);
    checkOutput("rst_data", {24'd0, DataOut}, 0);
    checkOutput("rst_good", {16'd0, GoodCnt}, 0);
    checkOutput("rst_errcnt", {16'd0, ErrCnt}, 0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    buildFrame(60, 1'b0); applyStimulus(1'b1, 1'b0, 1'b0, -1);
    buildFrame(60, 1'b1); applyStimulus(1'b1, 1'b0, 1'b0, -1);
    buildFrame(60, 1'b0); applyStimulus(1'b1, 1'b1, 1'b0, -1);
    buildFrame(60, 1'b0); applyStimulus(1'b1, 1'b0, 1'b0, -1);
    buildFrame(36, 1'b0); applyStimulus(1'b1, 1'b0, 1'b0, -1);
    buildFrame(60, 1'b0); applyStimulus(1'b1, 1'b0, 1'b1, -1);
    buildFrame(0, 1'b0);  applyStimulus(1'b1, 1'b0, 1'b0, -1);
    frm.delete();
    for (int i = 0; i < D; i++) frm.push_back(8'hA0 + 8'(i));
    applyStimulus(1'b1, 1'b0, 1'b0, -1);
    buildFrame(59, 1'b0); applyStimulus(1'b1, 1'b0, 1'b0, -1);
    buildFrame(60, 1'b0); applyStimulus(1'b0, 1'b0, 1'b0, -1);
    buildFrame(60, 1'b0); applyStimulus(1'b1, 1'b0, 1'b0, 8);
    buildFrame(60, 1'b0); applyStimulus(1'b1, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
